// File: rtl/riscv8_pkg.sv
// Shared definitions for the 8-bit RISC-V EX stage: ALU control encodings,
// the multi-cycle sequencer state type and the default datapath width.
package riscv8_pkg;

    localparam int DATA_W_DEF = 8;

    // Must stay in step with the ALU control decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// EX-stage bundle between the pipeline/ALU and the MUL sequencer.
// slave = sequencer side, master = pipeline side.
interface mul_seq_ctrl_if #(
    parameter int DATA_W = riscv8_pkg::DATA_W_DEF
) ();

    logic              start;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_own;
    logic [DATA_W-1:0] alu_in_a;
    logic [DATA_W-1:0] alu_in_b;
    logic [3:0]        alu_control;
    logic              stall;
    logic              busy;
    logic              result_valid;
    logic [DATA_W-1:0] result;

    modport slave (
        input  start, flush, op_a, op_b, alu_result,
        output alu_own, alu_in_a, alu_in_b, alu_control,
               stall, busy, result_valid, result
    );

    modport master (
        output start, flush, op_a, op_b, alu_result,
        input  alu_own, alu_in_a, alu_in_b, alu_control,
               stall, busy, result_valid, result
    );

endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add MUL sequencer: borrows the shared EX ALU for one ADD per
// multiplier bit, stalls the front end while it runs, then presents the low product.
module mul_seq_ctrl
    import riscv8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 3
) (
    input  logic          clk,
    input  logic          reset,
    mul_seq_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_t        r_state;
    mul_state_t        w_next;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_a_sh;
    logic [DATA_W-1:0] r_b_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_result;

    logic              w_accept;
    logic              w_last;
    logic              w_own;
    logic [DATA_W-1:0] w_acc_next;

    assign w_accept   = (r_state == IDLE) & bus.start & ~bus.flush;
    // Early exit once no multiplier bits remain above the current one
    assign w_last     = (r_cnt == CNT_LAST) || ((r_b_sh >> 1) == '0);
    assign w_acc_next = r_b_sh[0] ? bus.alu_result : r_acc;
    assign w_own      = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = (bus.op_b == '0) ? DONE : RUN;
            RUN: begin
                if (bus.flush)   w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_acc  <= '0;
            r_a_sh <= bus.op_a;
            r_b_sh <= bus.op_b;
            r_cnt  <= '0;
            if (bus.op_b == '0) r_result <= '0;
        end else if (w_own && !bus.flush) begin
            r_acc  <= w_acc_next;
            r_a_sh <= r_a_sh << 1;
            r_b_sh <= r_b_sh >> 1;
            r_cnt  <= r_cnt + 1'b1;
            // Output register is loaded on the edge that enters DONE
            if (w_last) r_result <= w_acc_next;
        end
    end

    assign bus.alu_own      = w_own;
    assign bus.alu_in_a     = w_own ? r_acc  : '0;
    assign bus.alu_in_b     = w_own ? r_a_sh : '0;
    assign bus.alu_control  = w_own ? ALU_ADD : ALU_AND;
    assign bus.stall        = w_accept | w_own;
    assign bus.busy         = (r_state != IDLE);
    assign bus.result_valid = (r_state == DONE) & ~bus.flush;
    assign bus.result       = r_result;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl: stimulus pushes expected products and
// timing windows, a negedge monitor compares every cycle against them.
module tb_mul_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   skip = 1'b0;
    logic [7:0] exp_result = 8'h00;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] prod;
        int         t;
        int         k;
    } exp_t;

    exp_t q[$];

    mul_seq_ctrl_if #(.DATA_W(8)) bus ();

    mul_seq_ctrl #(.DATA_W(8), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Shared ALU stand-in: only ADD produces a sum, anything else yields junk
    assign bus.alu_result = (bus.alu_control == 4'b0010) ? 8'(bus.alu_in_a + bus.alu_in_b) : 8'hA5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int kof(input logic [7:0] b);
        int k = 0;
        for (int i = 0; i < 8; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    // Partial product after the low (i-1) multiplier bits have been consumed
    function automatic int acc_model(input logic [7:0] a, input logic [7:0] b, input int i);
        int mask = (1 << (i - 1)) - 1;
        return (int'(a) * (int'(b) & mask)) & 255;
    endfunction

    always @(negedge clk) begin : monitor
        bit   has;
        exp_t e;
        int   i;
        bit   e_val, e_stall, e_busy, e_own;
        if (!rst && !skip) begin
            has = (q.size() != 0);
            e = '{8'h00, 8'h00, 8'h00, 0, 0};
            if (has) e = q[0];
            e_val   = has && (cyc == e.t + e.k + 1);
            e_stall = has && (cyc >= e.t) && (cyc <= e.t + e.k);
            e_busy  = has && (cyc > e.t) && (cyc <= e.t + e.k + 1);
            e_own   = has && (cyc > e.t) && (cyc <= e.t + e.k);
            chk("result_valid", int'(bus.result_valid), int'(e_val));
            chk("stall", int'(bus.stall), int'(e_stall));
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("alu_own", int'(bus.alu_own), int'(e_own));
            if (e_own) begin
                i = cyc - e.t;
                chk("alu_control", int'(bus.alu_control), 2);
                chk("alu_in_a", int'(bus.alu_in_a), acc_model(e.a, e.b, i));
                chk("alu_in_b", int'(bus.alu_in_b), (int'(e.a) << (i - 1)) & 255);
            end else begin
                chk("alu_in_a_idle", int'(bus.alu_in_a), 0);
                chk("alu_in_b_idle", int'(bus.alu_in_b), 0);
                chk("alu_control_idle", int'(bus.alu_control), 0);
            end
            if (e_val) begin
                chk("result", int'(bus.result), int'(e.prod));
                exp_result = e.prod;
                void'(q.pop_front());
            end else begin
                chk("result_hold", int'(bus.result), int'(exp_result));
            end
        end
    end

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, output int k);
        exp_t e;
        k = kof(b);
        e.a = a;
        e.b = b;
        e.prod = 8'((int'(a) * int'(b)) & 255);
        e.t = cyc;
        e.k = k;
        q.push_back(e);
    endtask

    // dup re-presents start with other operands during the first RUN cycle
    task automatic do_mul(input logic [7:0] a, input logic [7:0] b, input bit dup);
        int k;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b;
        push_exp(a, b, k);
        @(posedge clk); #1;
        if (dup && k > 0) begin
            bus.start = 1'b1; bus.op_a = ~a; bus.op_b = 8'h3C;
        end else begin
            bus.start = 1'b0;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (k) @(posedge clk);
    endtask

    task automatic flush_test();
        int k;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op_a = 8'd7; bus.op_b = 8'h80;
        push_exp(8'd7, 8'h80, k);
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b1; skip = 1'b1;
        void'(q.pop_back());
        @(posedge clk); #1;
        bus.flush = 1'b0; skip = 1'b0;
        do_mul(8'd6, 8'd6, 1'b0);
    endtask

    task automatic reset_test();
        int k;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op_a = 8'h55; bus.op_b = 8'hFF;
        push_exp(8'h55, 8'hFF, k);
        @(posedge clk); #1; bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        exp_result = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle_flush_test();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.op_a = 8'h11; bus.op_b = 8'h22;
        #1;
        chk("stall_idle_flush", int'(bus.stall), 0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("busy_after_idle_flush", int'(bus.busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ra, rb;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op_a  = 8'h00;
        bus.op_b  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_mul(8'd3, 8'd5, 1'b0);
        do_mul(8'hFF, 8'hFF, 1'b0);
        do_mul(8'h10, 8'h10, 1'b0);
        do_mul(8'h7A, 8'h00, 1'b0);
        flush_test();
        do_mul(8'd3, 8'd5, 1'b1);
        reset_test();
        idle_flush_test();

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
            do_mul(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
